// File: rtl/ov7670_frame_source.sv
// ov7670_frame_source: behavioural OV7670 transmitter producing RGB565 frames (vsync, back porch, href lines, front porch)
//   clk           byte clock (PCLK), rising edge
//   async_reset_n asynchronous reset, active low
//   enable        start/continue frames; sampled in IDLE and on the last cycle of a frame
//   vsync         frame sync, high for VS_LINES line periods
//   href          high while px_data carries pixel bytes
//   px_data       pixel byte, high byte first; zero while href is low
//   frame_done    one-cycle pulse on the last cycle of each frame
//   frame_cnt     completed frames, wraps at 256
// Define COLOR_BARS_EN to replace the {row, col} pattern with 8 vertical RGB565 colour bars.
module ov7670_frame_source #(
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 120,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic       clk,
  input  logic       async_reset_n,
  input  logic       enable,
  output logic       vsync,
  output logic       href,
  output logic [7:0] px_data,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);
  localparam int LINE_LEN = 2*WIDTH + H_BLANK;
  localparam int HW = $clog2(LINE_LEN);
  localparam int M1 = VS_LINES > VBP_LINES ? VS_LINES : VBP_LINES;
  localparam int M2 = HEIGHT > VFP_LINES ? HEIGHT : VFP_LINES;
  localparam int MAXL = M1 > M2 ? M1 : M2;
  localparam int LW = MAXL > 1 ? $clog2(MAXL) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT = HW'(2*WIDTH);
  localparam logic [LW-1:0] VS_M1 = LW'(VS_LINES - 1);
  localparam logic [LW-1:0] VBP_M1 = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] ACT_M1 = LW'(HEIGHT - 1);
  localparam logic [LW-1:0] VFP_M1 = LW'(VFP_LINES - 1);
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
  state_t r_state, w_state_nx;
  logic [HW-1:0] r_h, w_h_nx;
  logic [LW-1:0] r_line, w_line_nx, w_lim;
  logic w_h_end, w_st_end;
  logic r_vsync, r_href, r_done;
  logic [7:0] r_px, r_cnt;
  logic w_vsync_nx, w_href_nx, w_done_nx;
  logic [7:0] w_byte, w_px_nx;
`ifdef COLOR_BARS_EN
  localparam int BW = WIDTH/8 > 0 ? WIDTH/8 : 1;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [2:0] w_bar;
  logic [15:0] w_pix;
`else
  logic [7:0] w_row, w_col;
`endif
  assign vsync = r_vsync;
  assign href = r_href;
  assign px_data = r_px;
  assign frame_done = r_done;
  assign frame_cnt = r_cnt;
  always_ff @(posedge clk or negedge async_reset_n)
    if (!async_reset_n) begin
      r_state <= IDLE;
      r_h <= '0;
      r_line <= '0;
      r_vsync <= 1'b0;
      r_href <= 1'b0;
      r_px <= '0;
      r_done <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_h <= w_h_nx;
      r_line <= w_line_nx;
      r_vsync <= w_vsync_nx;
      r_href <= w_href_nx;
      r_px <= w_px_nx;
      r_done <= w_done_nx;
      r_cnt <= r_cnt + {7'd0, r_done};
    end
  // A state ends on the last h_cnt of its last line period; enable is only looked at in IDLE and at frame end.
  always_comb begin
    w_h_end = r_h == H_LAST;
    w_lim = r_state == VSYNC ? VS_M1 : r_state == VBP ? VBP_M1 : r_state == ACTIVE ? ACT_M1 : VFP_M1;
    w_st_end = w_h_end && r_line == w_lim;
    w_state_nx = r_state == IDLE ? (enable ? VSYNC : IDLE) :
                 !w_st_end ? r_state :
                 r_state == VSYNC ? VBP :
                 r_state == VBP ? ACTIVE :
                 r_state == ACTIVE ? VFP :
                 (enable ? VSYNC : IDLE);
    w_h_nx = (r_state == IDLE || w_h_end) ? '0 : r_h + HW'(1);
    w_line_nx = (r_state == IDLE || w_st_end) ? '0 : r_line + LW'(w_h_end);
  end
  // Outputs are decoded from the next-cycle state and counters so they can be registered without lag.
  always_comb begin
    w_vsync_nx = w_state_nx == VSYNC;
    w_href_nx = w_state_nx == ACTIVE && w_h_nx < H_ACT;
`ifdef COLOR_BARS_EN
    w_bar = 3'((w_h_nx >> 1) / HW'(BW));
    w_pix = BARS[w_bar];
    w_byte = w_h_nx[0] ? w_pix[7:0] : w_pix[15:8];
`else
    w_row = 8'(w_line_nx);
    w_col = 8'(w_h_nx >> 1);
    w_byte = w_h_nx[0] ? w_col : w_row;
`endif
    w_px_nx = w_href_nx ? w_byte : '0;
    w_done_nx = w_state_nx == VFP && w_h_nx == H_LAST && w_line_nx == VFP_M1;
  end
endmodule

// File: tb/tb_ov7670_frame_source.sv
// tb_ov7670_frame_source: random and directed checks of ov7670_frame_source against a frame-timeline model
module tb_ov7670_frame_source;
`ifdef COLOR_BARS_EN
  localparam int W = 16;
  localparam int NLIT = 10;
`else
  localparam int W = 4;
  localparam int NLIT = 8;
`endif
  localparam int H = 2, HB = 3, VS = 1, VBP = 1, VFP = 1;
  localparam int LL = 2*W + HB;
  localparam int FRAME = (VS + VBP + H + VFP) * LL;
  logic clk = 0, async_reset_n = 0, enable = 0;
  logic vsync, href, frame_done;
  logic [7:0] px_data, frame_cnt;
  int n_checks = 0, n_fail = 0;
  bit chk_on = 0;
  bit m_run = 0;
  int m_t = 0;
  int m_cnt = 0;
  logic [7:0] lit [10];
  ov7670_frame_source #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)) dut (
    .clk(clk), .async_reset_n(async_reset_n), .enable(enable), .vsync(vsync), .href(href),
    .px_data(px_data), .frame_done(frame_done), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a frame is just a cycle index t in 0..FRAME-1; everything else is arithmetic on t.
  always @(posedge clk or negedge async_reset_n)
    if (!async_reset_n) begin
      m_run <= 0;
      m_t <= 0;
      m_cnt <= 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run <= 1;
        m_t <= 0;
      end
    end else if (m_t == FRAME - 1) begin
      m_cnt <= (m_cnt + 1) % 256;
      m_run <= enable;
      m_t <= 0;
    end else m_t <= m_t + 1;
  function automatic logic [15:0] bar_pix(input int c);
    case (c / (W/8 > 0 ? W/8 : 1))
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction
  always @(negedge clk) if (chk_on) begin
    int line, h, a;
    logic e_vs, e_href, e_done;
    logic [7:0] e_px;
    logic [15:0] pix;
    line = m_t / LL;
    h = m_t % LL;
    a = line - VS - VBP;
    e_vs = m_run && line < VS;
    e_href = m_run && a >= 0 && a < H && h < 2*W;
`ifdef COLOR_BARS_EN
    pix = bar_pix(h/2);
`else
    pix = {8'(a), 8'(h/2)};
`endif
    e_px = !e_href ? 8'h00 : (h % 2 == 0) ? pix[15:8] : pix[7:0];
    e_done = m_run && m_t == FRAME - 1;
    check("vsync", {15'd0, vsync}, {15'd0, e_vs});
    check("href", {15'd0, href}, {15'd0, e_href});
    check("px_data", {8'd0, px_data}, {8'd0, e_px});
    check("frame_done", {15'd0, frame_done}, {15'd0, e_done});
    check("frame_cnt", {8'd0, frame_cnt}, 16'(m_cnt));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 1000);
  endtask
  task automatic wait_href();
    int n = 0;
    while (!href && n < 1000) begin
      step();
      n++;
    end
    check("href_timeout", {15'd0, href}, 16'd1);
  endtask
  initial begin
    int k, n, c0;
`ifdef COLOR_BARS_EN
    lit = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0, 8'h07, 8'hFF};
`else
    lit = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03, 8'h00, 8'h00};
`endif
    repeat (3) @(posedge clk);
    chk_on = 1;
    #1;
    check("rst_vsync", {15'd0, vsync}, 16'd0);
    check("rst_href", {15'd0, href}, 16'd0);
    check("rst_px", {8'd0, px_data}, 16'd0);
    check("rst_cnt", {8'd0, frame_cnt}, 16'd0);
    #1;
    async_reset_n = 1;
    enable = 1;
    step();
    check("vsync_first", {15'd0, vsync}, 16'd1);
    k = 0;
    while (vsync && k < 200) begin
      step();
      k++;
    end
    check("vsync_len", 16'(k), 16'(LL));
    while (!href && k < 400) begin
      step();
      k++;
    end
    check("href_rise", 16'(k), 16'(2*LL));
    repeat (LL) step();
    for (int i = 0; i < 2*W; i++) begin
      check("line1_href", {15'd0, href}, 16'd1);
      if (i < NLIT) check("line1_byte", {8'd0, px_data}, {8'd0, lit[i]});
      step();
    end
    for (int i = 0; i < HB; i++) begin
      check("blank_href", {15'd0, href}, 16'd0);
      check("blank_px", {8'd0, px_data}, 16'd0);
      step();
    end
    wait_done(n);
    check("cnt_before_done", {8'd0, frame_cnt}, 16'd0);
    step();
    check("cnt_1", {8'd0, frame_cnt}, 16'd1);
    wait_done(n);
    check("done_period", 16'(n + 1), 16'(FRAME));
    step();
    check("cnt_2", {8'd0, frame_cnt}, 16'd2);
    c0 = frame_cnt;
    repeat (256 * FRAME) step();
    check("cnt_wrap", {8'd0, frame_cnt}, 16'(c0));
    wait_href();
    #2;
    async_reset_n = 0;
    #1;
    check("arst_href", {15'd0, href}, 16'd0);
    check("arst_vsync", {15'd0, vsync}, 16'd0);
    check("arst_px", {8'd0, px_data}, 16'd0);
    @(posedge clk);
    #2;
    async_reset_n = 1;
    step();
    check("restart_vsync", {15'd0, vsync}, 16'd1);
    check("restart_cnt", {8'd0, frame_cnt}, 16'd0);
    wait_href();
    #1;
    enable = 0;
    wait_done(n);
    check("drop_done", {15'd0, frame_done}, 16'd1);
    step();
    check("drop_cnt", {8'd0, frame_cnt}, 16'd1);
    repeat (20) step();
    check("idle_vsync", {15'd0, vsync}, 16'd0);
    check("idle_href", {15'd0, href}, 16'd0);
    repeat (3000) begin
      @(posedge clk);
      #2;
      enable = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 499) == 0) begin
        async_reset_n = 0;
        #2;
        async_reset_n = 1;
      end
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ov7670_frame_source.md
Name: ov7670_frame_source

Overview:
- Behavioural OV7670 camera output generator: the transmit end of the VSYNC/HREF/byte-data interface that the capture logic samples.
- Produces one RGB565 frame at a time: vsync pulse, back porch, active lines with href-qualified bytes, then front porch.
- Used in simulation benches and on-board self-test in place of the real sensor; clk stands in for the sensor PCLK, one byte per clk.

Parameters:
- WIDTH, 160, active pixels per line (2 bytes each, so href is high 2*WIDTH cycles).
- HEIGHT, 120, active lines per frame.
- H_BLANK, 144, clk cycles with href low after each line's active bytes.
- VS_LINES, 3, line periods with vsync high.
- VBP_LINES, 17, line periods after vsync before the first active line.
- VFP_LINES, 10, line periods after the last active line.

Ports:
- clk  input  1  byte clock (PCLK equivalent), rising edge.
- async_reset_n  input  1  asynchronous reset, active low.
- enable  input  1  start/continue frame generation.
- vsync  output  1  frame sync, active high.
- href  output  1  line valid, high while px_data carries pixel bytes.
- px_data  output  8  pixel byte; first byte = pixel[15:8], second byte = pixel[7:0].
- frame_done  output  1  one-cycle pulse on the last cycle of each frame.
- frame_cnt  output  8  completed-frame counter; wraps 255 -> 0.

Behaviour:
- One clock; reset is asynchronous and active-low; all outputs registered.
- Reset, asserted at any time including mid-frame: state IDLE, vsync=0, href=0, px_data=0, frame_done=0, frame_cnt=0, all counters 0.
- LINE_LEN = 2*WIDTH + H_BLANK. h_cnt counts 0..LINE_LEN-1 and wraps. line_cnt counts line periods within the current state.
- FSM states:
  - IDLE: outputs low. The first edge with enable=1 enters VSYNC; vsync=1 in the cycle after that edge.
  - VSYNC: vsync=1 for exactly VS_LINES*LINE_LEN cycles, then VBP.
  - VBP: VBP_LINES*LINE_LEN cycles, then ACTIVE.
  - ACTIVE: HEIGHT line periods, then VFP. Within a line, href=1 for h_cnt 0..2*WIDTH-1 and 0 for the H_BLANK cycles.
  - VFP: VFP_LINES*LINE_LEN cycles. On its last cycle, frame_done=1 and frame_cnt increments at the closing edge. Next state is VSYNC if enable=1 at that edge, else IDLE.
- enable is sampled only in IDLE and at frame end. Deasserting it mid-frame completes the current frame; frames are never truncated.
- Pixel for row r (0..HEIGHT-1), column c (0..WIDTH-1) = {r[7:0], c[7:0]}.
  - Even h_cnt in the active window outputs r[7:0]; odd h_cnt outputs c[7:0].
- px_data=0 whenever href=0.
- vsync and href are never high in the same cycle.

Optional Feature:
- Macro COLOR_BARS_EN.
- Defined: the pixel is replaced by 8 vertical bars, each WIDTH/8 columns wide, bar index = c/(WIDTH/8). RGB565 values in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Byte order and timing are unchanged.
- Undefined: the {row, col} pattern above; no bar logic is synthesised.

Test Plan:
- Bench parameters WIDTH=4, HEIGHT=2, H_BLANK=3, VS_LINES=1, VBP_LINES=1, VFP_LINES=1 (LINE_LEN=11, frame=55 cycles).
- Reset release with enable=1: vsync=1 for exactly 11 cycles starting one cycle after the first enabled edge. href first rises 22 cycles after vsync rises.
- Active line 1: href high 8 cycles, px_data = 01,00,01,01,01,02,01,03, then href low 3 cycles with px_data=00.
- Continuous enable: frame_done pulses once every 55 cycles and frame_cnt counts 0,1,2. After 256 frames frame_cnt reads 0.
- enable dropped during ACTIVE of frame 0: frame completes normally, frame_done fires, block returns to IDLE with vsync=href=0 and frame_cnt=1.
- async_reset_n pulsed low during an href-high cycle: href, vsync, px_data go 0 immediately without a clk edge. After release with enable=1, a full frame restarts from VSYNC.
- With COLOR_BARS_EN, WIDTH=16: row 0 bytes are FF,FF,FF,FF,FF,E0,FF,E0,07,FF,… with bar 7 bytes 00,00.
